pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Consumes the next-PC decision (redirect strobe plus target) and owns the architectural PC register.
- Sequences instruction fetches to instruction memory over a valid/ready request and response interface.
- Presents each fetched instruction, with its PC and PC+4, to decode through a valid/ready handshake.
- Sits between the PC-select logic and the decode stage; at most one memory request is outstanding at a time.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value driven on instr while no valid instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- pcSrc  input  1  one-cycle redirect strobe from branch/jump resolution
- pcTarget  input  32  redirect address; sampled only when pcSrc=1
- imemReqValid  output  1  fetch request valid
- imemReqReady  input  1  memory accepts request
- imemAddr  output  32  fetch address
- imemRspValid  input  1  response data valid; one-cycle pulse
- imemRspData  input  32  fetched instruction word
- instrValid  output  1  instruction available to decode
- instrReady  input  1  decode accepts instruction
- instr  output  32  held instruction
- pc  output  32  PC of held instruction
- pcPlus4  output  32  pc+4, mod 2^32

Behaviour:
- Reset (async assert, sync release): state=FETCH, fetchPc=RESET_PC, pc=RESET_PC, instr=NOP_INSTR, instrValid=0. imemReqValid is 0 while reset is high and asserts on the first cycle after release.
- imemAddr=fetchPc always. pcPlus4=pc+32'd4, combinational, wrapping 0xFFFF_FFFC→0x0000_0000. fetchPc increments by 4 with the same wrap.
- States FETCH, WAIT, HOLD, DROP. pcSrc has priority over every other event in every state.
- FETCH: imemReqValid=1.
  - Handshake (valid&&ready) with no redirect → WAIT.
  - pcSrc && !imemReqReady: fetchPc←pcTarget, stay FETCH. This is the only case in which imemAddr may change while imemReqValid=1.
  - pcSrc && imemReqReady: fetchPc←pcTarget → DROP.
- WAIT: imemReqValid=0.
  - imemRspValid: instr←imemRspData, pc←fetchPc → HOLD. instrValid rises on the next cycle (1-cycle response-to-decode latency).
  - pcSrc && imemRspValid: discard data, fetchPc←pcTarget → FETCH.
  - pcSrc && !imemRspValid: fetchPc←pcTarget → DROP.
- HOLD: instrValid=1; instr and pc held stable until accepted.
  - instrReady: fetchPc←fetchPc+4, instrValid←0 → FETCH.
  - pcSrc (with or without instrReady): instruction flushed (instrValid←0, instr←NOP_INSTR), fetchPc←pcTarget → FETCH.
- DROP: imemReqValid=0. Waits for the stale response.
  - imemRspValid: discard → FETCH.
  - pcSrc in DROP: fetchPc←pcTarget, stay DROP.
- Steady-state throughput: one instruction per 3 cycles with zero-wait memory and instrReady=1.
- instrValid never asserts for a response whose request preceded a redirect.
- Reset mid-operation: immediate return to reset values. Any in-flight response after release is ignored only if it arrives before the first new handshake; the memory side must drop outstanding requests on reset.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalignErr (1 bit, reset 0).
  - pcSrc with pcTarget[1:0]!=0: target is not loaded, fetchPc is unchanged, current state actions proceed as if pcSrc=0, misalignErr←1 (sticky until reset).
- Undefined:
  - No port.
  - pcTarget[1:0] are forced to 0 when loaded.

Test Plan:
- Reset release, zero-wait memory (rsp 1 cycle after req handshake), instrReady=1 → imemAddr sequence 0x0,0x4,0x8; pc=0x0 with pcPlus4=0x4 on first instrValid; 3-cycle spacing.
- HOLD with instrReady=0 for 5 cycles → instrValid, instr, pc stable; imemReqValid=0 throughout; next request issued at 0x4 after instrReady.
- pcSrc=1, pcTarget=0x00BC614C pulsed in WAIT before response → response discarded, no instrValid; next imemAddr=0x00BC614C.
- pcSrc pulsed in HOLD with instrReady=1 in the same cycle → instruction not consumed as sequential; next imemAddr=pcTarget, not pc+4.
- fetchPc=0xFFFF_FFFC → pcPlus4=0x0000_0000; following fetch at 0x0.
- PC_MISALIGN_TRAP_EN defined, pcTarget=0x0000_0102 → misalignErr=1, fetch continues sequentially. Undefined → fetch at 0x0000_0100.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the architectural PC, sequences one-at-a-time fetches to
// instruction memory and hands each fetched word (with pc / pc+4) to decode.
// Optional macro PC_MISALIGN_TRAP_EN: reject redirects to non-word-aligned
// targets and raise a sticky misalignErr flag; otherwise targets are
// word-aligned by clearing bits [1:0].
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcSrc,
    input  logic [31:0] pcTarget,
    output logic        imemReqValid,
    input  logic        imemReqReady,
    output logic [31:0] imemAddr,
    input  logic        imemRspValid,
    input  logic [31:0] imemRspData,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic        misalignErr
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        req_q;
    logic        valid_q;
    logic        redirect;
    logic        req_hs;
    logic [31:0] target;

`ifdef PC_MISALIGN_TRAP_EN
    logic err_q, err_d;

    // Misaligned redirects are ignored and flagged instead of loaded.
    assign redirect = pcSrc && (pcTarget[1:0] == 2'b00);
    assign target   = pcTarget;
    assign err_d    = err_q || (pcSrc && (pcTarget[1:0] != 2'b00));
    assign misalignErr = err_q;
`else
    // Redirect targets are forced onto a word boundary.
    assign redirect = pcSrc;
    assign target   = pcTarget & 32'hFFFF_FFFC;
`endif

    assign req_hs = req_q && imemReqReady;

    // Next-state and datapath update; redirect wins over every other event.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    state_d    = req_hs ? S_DROP : S_FETCH;
                end else if (req_hs) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    state_d    = imemRspValid ? S_FETCH : S_DROP;
                end else if (imemRspValid) begin
                    instr_d = imemRspData;
                    pc_d    = fetch_pc_q;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    instr_d    = NOP_INSTR;
                    state_d    = S_FETCH;
                end else if (instrReady) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    instr_d    = NOP_INSTR;
                    state_d    = S_FETCH;
                end
            end
            S_DROP: begin
                // A redirect coinciding with the stale response still retires it,
                // otherwise DROP would wait for a response that never comes.
                if (redirect) begin
                    fetch_pc_d = target;
                    state_d    = imemRspValid ? S_FETCH : S_DROP;
                end else if (imemRspValid) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State and registered outputs; handshake outputs follow the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            req_q      <= (state_d == S_FETCH);
            valid_q    <= (state_d == S_HOLD);
`ifdef PC_MISALIGN_TRAP_EN
            err_q      <= err_d;
`endif
        end
    end

    assign imemReqValid = req_q;
    assign imemAddr     = fetch_pc_q;
    assign instrValid   = valid_q;
    assign instr        = instr_q;
    assign pc           = pc_q;
    assign pcPlus4      = pc_q + 32'd4;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a small latency-programmable memory.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] DKEY = 32'h1357_9BDF;  // rsp data = addr ^ DKEY

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pcSrc = 1'b0;
    logic [31:0] pcTarget = 32'h0;
    logic        imemReqValid;
    logic        imemReqReady = 1'b1;
    logic [31:0] imemAddr;
    logic        imemRspValid = 1'b0;
    logic [31:0] imemRspData = 32'h0;
    logic        instrValid;
    logic        instrReady = 1'b1;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalignErr;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int rsp_delay = 1;
    int mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;

    pc_fetch_ctrl dut (
        .clk(clk), .reset(reset), .pcSrc(pcSrc), .pcTarget(pcTarget),
        .imemReqValid(imemReqValid), .imemReqReady(imemReqReady), .imemAddr(imemAddr),
        .imemRspValid(imemRspValid), .imemRspData(imemRspData),
        .instrValid(instrValid), .instrReady(instrReady), .instr(instr),
        .pc(pc), .pcPlus4(pcPlus4)
`ifdef PC_MISALIGN_TRAP_EN
        , .misalignErr(misalignErr)
`endif
    );

    always #5 clk = ~clk;

    // Memory: detects a handshake before the edge, answers rsp_delay cycles later.
    always begin
        @(posedge clk);
        #1;
        imemRspValid = 1'b0;
        if (reset) begin
            mem_cnt = 0;
        end else if (mem_cnt > 0) begin
            mem_cnt = mem_cnt - 1;
            if (mem_cnt == 0) begin
                imemRspValid = 1'b1;
                imemRspData  = mem_addr ^ DKEY;
            end
        end
        @(negedge clk);
        #1;
        if (!reset && imemReqValid && imemReqReady) begin
            mem_cnt  = rsp_delay;
            mem_addr = imemAddr;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (instrValid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (imemReqValid !== 1'b0 || instrValid !== 1'b0) $display("FAIL reset_valids req=%b iv=%b want 0/0", imemReqValid, instrValid);
        else n_pass++;
        n_checks++;
        if (instr !== NOP || pc !== 32'h0 || pcPlus4 !== 32'h4 || imemAddr !== 32'h0)
            $display("FAIL reset_values instr=%h pc=%h pc4=%h addr=%h want %h/0/4/0", instr, pc, pcPlus4, imemAddr, NOP);
        else n_pass++;
`ifdef PC_MISALIGN_TRAP_EN
        n_checks++;
        if (misalignErr !== 1'b0) $display("FAIL reset_misalign got %b want 0", misalignErr);
        else n_pass++;
`endif
    endtask

    task automatic test_sequential();
        logic [31:0] addrs [3];
        int vcyc [3];
        logic [31:0] vinstr0, vpc0, vpc4_0;
        int na = 0, nv = 0;
        instrReady = 1'b1; imemReqReady = 1'b1; rsp_delay = 1;
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (imemReqValid && na < 3) begin addrs[na] = imemAddr; na++; end
            if (instrValid && nv < 3) begin
                if (nv == 0) begin vinstr0 = instr; vpc0 = pc; vpc4_0 = pcPlus4; end
                vcyc[nv] = c; nv++;
            end
        end
        n_checks++;
        if (na != 3 || addrs[0] !== 32'h0 || addrs[1] !== 32'h4 || addrs[2] !== 32'h8)
            $display("FAIL seq_addrs n=%0d a=%h,%h,%h want 3 0,4,8", na, addrs[0], addrs[1], addrs[2]);
        else n_pass++;
        n_checks++;
        if (nv < 1 || vpc0 !== 32'h0 || vpc4_0 !== 32'h4 || vinstr0 !== 32'h1357_9BDF)
            $display("FAIL seq_first n=%0d pc=%h pc4=%h instr=%h want 0/4/13579bdf", nv, vpc0, vpc4_0, vinstr0);
        else n_pass++;
        n_checks++;
        if (nv != 3 || vcyc[0] != 3 || vcyc[1] - vcyc[0] != 3 || vcyc[2] - vcyc[1] != 3)
            $display("FAIL seq_spacing n=%0d cyc=%0d,%0d,%0d want 3,6,9", nv, vcyc[0], vcyc[1], vcyc[2]);
        else n_pass++;
    endtask

    task automatic test_hold_stall();
        bit ok;
        instrReady = 1'b0;
        do_reset();
        wait_valid(10, ok);
        n_checks++;
        if (!ok) $display("FAIL stall_timeout instrValid=%b want 1", instrValid);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (instrValid !== 1'b1 || instr !== 32'h1357_9BDF || pc !== 32'h0 || imemReqValid !== 1'b0)
                $display("FAIL stall_hold%0d iv=%b instr=%h pc=%h req=%b want 1/13579bdf/0/0", i, instrValid, instr, pc, imemReqValid);
            else n_pass++;
        end
        instrReady = 1'b1;
        @(negedge clk);
        n_checks++;
        if (imemReqValid !== 1'b1 || imemAddr !== 32'h4 || instrValid !== 1'b0 || instr !== NOP)
            $display("FAIL stall_release req=%b addr=%h iv=%b instr=%h want 1/4/0/nop", imemReqValid, imemAddr, instrValid, instr);
        else n_pass++;
    endtask

    task automatic test_redirect_wait();
        logic [31:0] first_addr = 32'hDEAD_BEEF, first_pc = 32'hDEAD_BEEF, first_instr = 32'h0;
        bit got_req = 1'b0, got_v = 1'b0;
        instrReady = 1'b1; rsp_delay = 3;
        do_reset();
        @(negedge clk);                     // request cycle at address 0
        @(negedge clk);                     // now in WAIT, response pending
        pcSrc = 1'b1; pcTarget = 32'h00BC_614C; rsp_delay = 1;
        @(negedge clk);
        pcSrc = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (imemReqValid && !got_req) begin got_req = 1'b1; first_addr = imemAddr; end
            if (instrValid && !got_v) begin got_v = 1'b1; first_pc = pc; first_instr = instr; end
            @(negedge clk);
        end
        n_checks++;
        if (first_addr !== 32'h00BC_614C) $display("FAIL rdw_addr got %h want 00bc614c", first_addr);
        else n_pass++;
        n_checks++;
        if (first_pc !== 32'h00BC_614C || first_instr !== 32'h13EB_FA93)
            $display("FAIL rdw_first_valid pc=%h instr=%h want 00bc614c/13ebfa93", first_pc, first_instr);
        else n_pass++;
    endtask

    task automatic test_redirect_hold();
        bit ok;
        instrReady = 1'b0; rsp_delay = 1;
        do_reset();
        wait_valid(10, ok);
        n_checks++;
        if (!ok) $display("FAIL rdh_timeout instrValid=%b want 1", instrValid);
        else n_pass++;
        instrReady = 1'b1; pcSrc = 1'b1; pcTarget = 32'h0000_0200;
        @(negedge clk);
        pcSrc = 1'b0;
        n_checks++;
        if (imemReqValid !== 1'b1 || imemAddr !== 32'h200 || instrValid !== 1'b0 || instr !== NOP)
            $display("FAIL rdh_next req=%b addr=%h iv=%b instr=%h want 1/200/0/nop", imemReqValid, imemAddr, instrValid, instr);
        else n_pass++;
    endtask

    task automatic test_wrap();
        bit ok;
        instrReady = 1'b0; imemReqReady = 1'b0; rsp_delay = 1;
        do_reset();
        pcSrc = 1'b1; pcTarget = 32'hFFFF_FFFC;
        @(negedge clk);
        pcSrc = 1'b0;
        n_checks++;
        if (imemReqValid !== 1'b1 || imemAddr !== 32'hFFFF_FFFC)
            $display("FAIL wrap_stall_redirect req=%b addr=%h want 1/fffffffc", imemReqValid, imemAddr);
        else n_pass++;
        imemReqReady = 1'b1;
        wait_valid(10, ok);
        n_checks++;
        if (!ok || pc !== 32'hFFFF_FFFC || pcPlus4 !== 32'h0 || instr !== 32'hECA8_6423)
            $display("FAIL wrap_hold ok=%b pc=%h pc4=%h instr=%h want fffffffc/0/eca86423", ok, pc, pcPlus4, instr);
        else n_pass++;
        instrReady = 1'b1;
        @(negedge clk);
        n_checks++;
        if (imemReqValid !== 1'b1 || imemAddr !== 32'h0)
            $display("FAIL wrap_next req=%b addr=%h want 1/0", imemReqValid, imemAddr);
        else n_pass++;
    endtask

    task automatic test_misalign();
        instrReady = 1'b1; imemReqReady = 1'b0;
        do_reset();
        pcSrc = 1'b1; pcTarget = 32'h0000_0102;
        @(negedge clk);
        pcSrc = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        n_checks++;
        if (imemAddr !== 32'h0 || imemReqValid !== 1'b1)
            $display("FAIL mis_addr req=%b addr=%h want 1/0", imemReqValid, imemAddr);
        else n_pass++;
        n_checks++;
        if (misalignErr !== 1'b1) $display("FAIL mis_err got %b want 1", misalignErr);
        else n_pass++;
`else
        n_checks++;
        if (imemAddr !== 32'h100 || imemReqValid !== 1'b1)
            $display("FAIL mis_align req=%b addr=%h want 1/100", imemReqValid, imemAddr);
        else n_pass++;
`endif
        imemReqReady = 1'b1;
    endtask

    task automatic test_back_to_back();
        int nv = 0;
        logic [31:0] last_pc = 32'hDEAD_BEEF;
        instrReady = 1'b1; imemReqReady = 1'b1; rsp_delay = 1;
        do_reset();
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (instrValid) begin nv++; last_pc = pc; end
        end
        n_checks++;
        if (nv != 10 || last_pc !== 32'h24)
            $display("FAIL b2b_count n=%0d last_pc=%h want 10/24", nv, last_pc);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_misalign();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
